// File: rtl/class_hv_binarizer.sv
// ---------------------------------------------------------------------------
// class_hv_binarizer
//
// Walks the accumulated class hypervector counter memory in class-major,
// chunk-minor order, thresholds every per-dimension counter against the
// number of training samples seen by that class (strict majority), and
// streams the resulting binary chunks downstream over valid/ready.
// binarizing_o is high for the whole pass so the class bundler can switch
// into pass-through while its counters are being consumed.
//
// Optional feature macro: CLASS_CLEAR_EN
//   defined   : a clear strobe (wr_en_o) is issued in WAIT for the chunk just
//               read, so the pass leaves the counter memory zeroed.
//   undefined : wr_en_o / wr_class_o / wr_chunk_o are tied to 0.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start_i           one-cycle pulse, starts a full pass (ignored unless idle)
//   rd_en_o           counter memory read strobe (single-cycle pulse)
//   rd_class_o        class address of the read
//   rd_chunk_o        chunk address of the read
//   rd_data_i         DIMS_PER_CC counters, valid one cycle after rd_en_o
//   sample_cnt_i      sample count of the addressed class, valid with rd_data_i
//   wr_en_o           counter clear strobe (CLASS_CLEAR_EN only)
//   wr_class_o        clear class address
//   wr_chunk_o        clear chunk address
//   bin_chunk_o       registered binarized chunk
//   bin_class_o       class tag of bin_chunk_o
//   bin_chunk_idx_o   chunk tag of bin_chunk_o
//   bin_valid_o       output valid
//   bin_ready_i       downstream ready
//   binarizing_o      high whenever the FSM is not idle
//   done_o            one-cycle pulse after the last chunk is accepted
// ---------------------------------------------------------------------------
module class_hv_binarizer #(
    parameter int DIMS_PER_CC      = 1024,
    parameter int BITWIDTH_PER_DIM = 9,
    parameter int NUM_CC           = 10,
    parameter int NUM_CLASSES      = 26
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start_i,
    output logic                                    rd_en_o,
    output logic [$clog2(NUM_CLASSES)-1:0]          rd_class_o,
    output logic [$clog2(NUM_CC)-1:0]               rd_chunk_o,
    input  logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0] rd_data_i,
    input  logic [BITWIDTH_PER_DIM-1:0]             sample_cnt_i,
    output logic                                    wr_en_o,
    output logic [$clog2(NUM_CLASSES)-1:0]          wr_class_o,
    output logic [$clog2(NUM_CC)-1:0]               wr_chunk_o,
    output logic [DIMS_PER_CC-1:0]                  bin_chunk_o,
    output logic [$clog2(NUM_CLASSES)-1:0]          bin_class_o,
    output logic [$clog2(NUM_CC)-1:0]               bin_chunk_idx_o,
    output logic                                    bin_valid_o,
    input  logic                                    bin_ready_i,
    output logic                                    binarizing_o,
    output logic                                    done_o
);

    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam int CC_W  = $clog2(NUM_CC);
    localparam int BW    = BITWIDTH_PER_DIM;

    localparam logic [CLS_W-1:0] LAST_CLASS = CLS_W'(NUM_CLASSES - 1);
    localparam logic [CC_W-1:0]  LAST_CHUNK = CC_W'(NUM_CC - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [CLS_W-1:0]       class_q, class_d;
    logic [CC_W-1:0]        chunk_q, chunk_d;
    logic [DIMS_PER_CC-1:0] bin_q;
    logic [CLS_W-1:0]       bin_class_q;
    logic [CC_W-1:0]        bin_chunk_q;
    logic [DIMS_PER_CC-1:0] thr;

    // Strict-majority threshold: 2*cnt > samples, evaluated one bit wider so
    // the doubling never overflows. A tie yields 0; with zero samples any
    // nonzero counter yields 1.
    always_comb begin
        thr = '0;
        for (int unsigned d = 0; d < DIMS_PER_CC; d++) begin
            thr[d] = ({1'b0, rd_data_i[d*BW +: BW]} << 1) > {1'b0, sample_cnt_i};
        end
    end

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        chunk_d = chunk_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_READ;
                    class_d = '0;
                    chunk_d = '0;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: state_d = S_OUT;
            S_OUT: begin
                if (bin_ready_i) begin
                    state_d = S_READ;
                    if (chunk_q == LAST_CHUNK) begin
                        chunk_d = '0;
                        if (class_q == LAST_CLASS) begin
                            // Indices wrap to 0 so the read address idles at 0.
                            class_d = '0;
                            state_d = S_DONE;
                        end else begin
                            class_d = class_q + CLS_W'(1);
                        end
                    end else begin
                        chunk_d = chunk_q + CC_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            class_q <= '0;
            chunk_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            chunk_q <= chunk_d;
        end
    end

    // Output register is loaded only in WAIT (read data is valid then) and
    // holds through any backpressure in OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q       <= '0;
            bin_class_q <= '0;
            bin_chunk_q <= '0;
        end else if (state_q == S_WAIT) begin
            bin_q       <= thr;
            bin_class_q <= class_q;
            bin_chunk_q <= chunk_q;
        end
    end

    assign rd_en_o         = (state_q == S_READ);
    assign rd_class_o      = class_q;
    assign rd_chunk_o      = chunk_q;
    assign bin_chunk_o     = bin_q;
    assign bin_class_o     = bin_class_q;
    assign bin_chunk_idx_o = bin_chunk_q;
    assign bin_valid_o     = (state_q == S_OUT);
    assign binarizing_o    = (state_q != S_IDLE);
    assign done_o          = (state_q == S_DONE);

`ifdef CLASS_CLEAR_EN
    // Indices are still those of the preceding read while in WAIT.
    assign wr_en_o    = (state_q == S_WAIT);
    assign wr_class_o = class_q;
    assign wr_chunk_o = chunk_q;
`else
    assign wr_en_o    = 1'b0;
    assign wr_class_o = '0;
    assign wr_chunk_o = '0;
`endif

endmodule

// File: tb/tb_class_hv_binarizer.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for class_hv_binarizer. Expected chunks for a pass are
// queued when the pass is started; a monitor pops and compares on every
// output handshake. The counter memory model answers reads exactly one cycle
// after rd_en_o and drives all-ones garbage at every other time.
// ---------------------------------------------------------------------------
module tb_class_hv_binarizer;

    localparam int D     = 1024;
    localparam int BW    = 9;
    localparam int NCC   = 10;
    localparam int NCLS  = 26;
    localparam int CLS_W = 5;
    localparam int CC_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              rd_en_o;
    logic [CLS_W-1:0]  rd_class_o;
    logic [CC_W-1:0]   rd_chunk_o;
    logic [D*BW-1:0]   rd_data_i;
    logic [BW-1:0]     sample_cnt_i;
    logic              wr_en_o;
    logic [CLS_W-1:0]  wr_class_o;
    logic [CC_W-1:0]   wr_chunk_o;
    logic [D-1:0]      bin_chunk_o;
    logic [CLS_W-1:0]  bin_class_o;
    logic [CC_W-1:0]   bin_chunk_idx_o;
    logic              bin_valid_o;
    logic              bin_ready_i;
    logic              binarizing_o;
    logic              done_o;

    class_hv_binarizer #(
        .DIMS_PER_CC(D), .BITWIDTH_PER_DIM(BW), .NUM_CC(NCC), .NUM_CLASSES(NCLS)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .rd_en_o(rd_en_o), .rd_class_o(rd_class_o), .rd_chunk_o(rd_chunk_o),
        .rd_data_i(rd_data_i), .sample_cnt_i(sample_cnt_i),
        .wr_en_o(wr_en_o), .wr_class_o(wr_class_o), .wr_chunk_o(wr_chunk_o),
        .bin_chunk_o(bin_chunk_o), .bin_class_o(bin_class_o),
        .bin_chunk_idx_o(bin_chunk_idx_o), .bin_valid_o(bin_valid_o),
        .bin_ready_i(bin_ready_i), .binarizing_o(binarizing_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cls;
        int          chk;
        logic [D-1:0] bits;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   hs_cnt = 0;
    int   wr_cnt = 0;

    logic             rd_pend = 1'b0;
    logic [CLS_W-1:0] lr_cls  = '0;
    logic [CC_W-1:0]  lr_chk  = '0;

    // Sample count per class (class mod 4): 10, 0, 9, 511.
    function automatic logic [BW-1:0] samp(input int c);
        case (c % 4)
            0: samp = 9'd10;
            1: samp = 9'd0;
            2: samp = 9'd9;
            default: samp = 9'd511;
        endcase
    endfunction

    // Counters: dims 0..3 = 6, 5, 0, 511; dim 4 = class; dim 5 = chunk;
    // dim 1023 = 511; all other dims 0.
    function automatic logic [D*BW-1:0] mem_data(input int c, input int k);
        logic [D*BW-1:0] v;
        v = '0;
        v[0*BW +: BW]    = 9'd6;
        v[1*BW +: BW]    = 9'd5;
        v[3*BW +: BW]    = 9'd511;
        v[4*BW +: BW]    = BW'(c);
        v[5*BW +: BW]    = BW'(k);
        v[1023*BW +: BW] = 9'd511;
        return v;
    endfunction

    // Dims 0..3 hand-computed per sample count:
    //   10 : 12>10,10>10,0>10,1022>10 -> 1,0,0,1
    //    0 : nonzero counters          -> 1,1,0,1
    //    9 : 12>9, 10>9, 0>9, 1022>9   -> 1,1,0,1
    //  511 : 12,10,0 no; 1022>511      -> 0,0,0,1
    function automatic logic [D-1:0] exp_bits(input int c, input int k);
        logic [D-1:0] b;
        b = '0;
        case (c % 4)
            0: b[3:0] = 4'b1001;
            1: b[3:0] = 4'b1011;
            2: b[3:0] = 4'b1011;
            default: b[3:0] = 4'b1000;
        endcase
        b[4]    = (2 * c) > int'(samp(c));
        b[5]    = (2 * k) > int'(samp(c));
        b[1023] = 1'b1;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic push_pass();
        exp_t e;
        for (int c = 0; c < NCLS; c++) begin
            for (int k = 0; k < NCC; k++) begin
                e.cls  = c;
                e.chk  = k;
                e.bits = exp_bits(c, k);
                sb.push_back(e);
            end
        end
    endtask

    // Counter memory: capture read request, present data one cycle later.
    always @(negedge clk) begin
        rd_pend = rd_en_o;
        if (rd_en_o) begin
            lr_cls = rd_class_o;
            lr_chk = rd_chunk_o;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rd_pend) begin
            rd_data_i    = mem_data(int'(lr_cls), int'(lr_chk));
            sample_cnt_i = samp(int'(lr_cls));
        end else begin
            rd_data_i    = '1;
            sample_cnt_i = '0;
        end
    end

    // Monitor: inputs settle at negedge, so at negedge+2 valid&&ready
    // predicts the handshake on the coming posedge.
    always @(negedge clk) begin
        exp_t e;
        int   diff;
        #2;
        if (!rst && bin_valid_o && bin_ready_i) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow: got tag %0d/%0d with no expected entry",
                         bin_class_o, bin_chunk_idx_o);
            end else begin
                e = sb.pop_front();
                chk("bin_tag", {bin_class_o, bin_chunk_idx_o},
                    {CLS_W'(e.cls), CC_W'(e.chk)});
                n_chk++;
                if (bin_chunk_o !== e.bits) begin
                    n_fail++;
                    diff = -1;
                    for (int i = D - 1; i >= 0; i--)
                        if (bin_chunk_o[i] !== e.bits[i]) diff = i;
                    $display("FAIL bin_data (%0d,%0d): first diff dim %0d, got low %h expected low %h",
                             e.cls, e.chk, diff, bin_chunk_o[63:0], e.bits[63:0]);
                end
            end
        end
        if (!rst && wr_en_o) begin
            wr_cnt++;
            chk("wr_addr", {wr_class_o, wr_chunk_o}, {lr_cls, lr_chk});
        end
    end

    task automatic run_pass(input bit stall);
        int k;
        int done_at;
        int st;
        int sc;
        hs_cnt = 0;
        wr_cnt = 0;
        push_pass();
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        @(negedge clk);
        chk("first_rd", {rd_en_o, binarizing_o, rd_class_o, rd_chunk_o},
            {1'b1, 1'b1, 5'd0, 4'd0});
        k = 1; done_at = 0; st = 0; sc = 0;
        while (k < 2000 && done_at == 0) begin
            @(negedge clk);
            k++;
            if (done_o) done_at = k;
            if (stall) begin
                if (k == 100) start_i = 1'b1;
                else if (k == 101) start_i = 1'b0;
                if (st == 0 && bin_valid_o && bin_class_o == 5'd2 && bin_chunk_idx_o == 4'd4) begin
                    bin_ready_i = 1'b0;
                    st = 1;
                end else if (st == 1) begin
                    sc++;
                    chk("stall_hold",
                        {bin_valid_o, rd_en_o, bin_class_o, bin_chunk_idx_o,
                         (bin_chunk_o === exp_bits(2, 4))},
                        {1'b1, 1'b0, 5'd2, 4'd4, 1'b1});
                    if (sc == 20) begin
                        bin_ready_i = 1'b1;
                        st = 2;
                    end
                end
            end
        end
        chk(stall ? "done_cycle_stall" : "done_cycle", done_at, stall ? 801 : 781);
        @(negedge clk);
        chk("idle_after", {binarizing_o, done_o}, 2'b00);
        #3;
        chk("handshakes", hs_cnt, 260);
        chk("sb_empty", sb.size(), 0);
`ifdef CLASS_CLEAR_EN
        chk("wr_count", wr_cnt, 260);
`else
        chk("wr_count", wr_cnt, 0);
`endif
    endtask

    task automatic check_all_zero(input string nm);
        chk(nm, |{rd_en_o, rd_class_o, rd_chunk_o, wr_en_o, wr_class_o, wr_chunk_o,
                  bin_chunk_o, bin_class_o, bin_chunk_idx_o, bin_valid_o,
                  binarizing_o, done_o}, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst          = 1'b1;
        start_i      = 1'b0;
        bin_ready_i  = 1'b1;
        rd_data_i    = '1;
        sample_cnt_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outs");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle_outs");

        run_pass(1'b0);
        run_pass(1'b1);

        // Abort mid-pass at chunk (5,3) with an asynchronous reset.
        push_pass();
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        k = 0;
        while (k < 1000 && !(bin_valid_o && bin_class_o == 5'd5 && bin_chunk_idx_o == 4'd3)) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reach", (k < 1000), 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b0;

        run_pass(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/class_hv_binarizer.md
# class_hv_binarizer

Sequential reader that walks the accumulated (non-binary) class hypervector memory chunk by chunk and thresholds each per-dimension counter into a binary class hypervector chunk. It streams those binary chunks downstream over a valid/ready handshake. It is the consumer of the counters the class bundler writes during training. While it runs it holds `binarizing_o` high, which switches the bundler into pass-through.

## Interface
- `DIMS_PER_CC`, 1024, dimensions per chunk.
- `BITWIDTH_PER_DIM`, 9, counter width per dimension.
- `NUM_CC`, 10, chunks per hypervector.
- `NUM_CLASSES`, 26, number of classes.

Clocking and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.

- `clk  in  1  clock`
- `rst  in  1  asynchronous active-high reset`
- `start_i  in  1  one-cycle pulse; begins a full pass`
- `rd_en_o  out  1  counter memory read strobe`
- `rd_class_o  out  $clog2(NUM_CLASSES)  class address`
- `rd_chunk_o  out  $clog2(NUM_CC)  chunk address`
- `rd_data_i  in  DIMS_PER_CC*BITWIDTH_PER_DIM  counters; valid exactly 1 cycle after rd_en_o`
- `sample_cnt_i  in  BITWIDTH_PER_DIM  training samples of addressed class; sampled with rd_data_i`
- `wr_en_o  out  1  counter clear strobe (CLASS_CLEAR_EN only)`
- `wr_class_o, wr_chunk_o  out  as rd_*  clear address`
- `bin_chunk_o  out  DIMS_PER_CC  binarized chunk`
- `bin_class_o, bin_chunk_idx_o  out  as rd_*  tag of bin_chunk_o`
- `bin_valid_o  out  1  output valid`
- `bin_ready_i  in  1  downstream ready`
- `binarizing_o  out  1  high whenever not IDLE`
- `done_o  out  1  one-cycle pulse after last chunk accepted`

## Operation
- States:
  - IDLE: `start_i` causes a move to READ and clears the class and chunk indices to 0.
  - READ: `rd_en_o`=1; next state is WAIT.
  - WAIT: registers the threshold result into the output register; next state is OUT.
  - OUT: `bin_valid_o`=1 until `bin_ready_i`. On handshake, advance the indices and go to READ, or go to DONE if this was the last chunk.
  - DONE: `done_o`=1 for one cycle; next state is IDLE.
- Order: class outer, chunk inner: (0,0),(0,1)…(0,NUM_CC-1),(1,0)…(NUM_CLASSES-1,NUM_CC-1).
- Threshold per dimension d: `bin[d] = ({1'b0,cnt[d]} << 1) > {1'b0,sample_cnt}`, evaluated at BITWIDTH_PER_DIM+1 bits.
  - Strict majority; a tie gives 0.
  - `sample_cnt`=0 gives 1 for any nonzero counter and 0 for a zero counter.
- `start_i` outside IDLE is ignored.
- `bin_chunk_o`, `bin_class_o` and `bin_chunk_idx_o` are registered and stay stable while `bin_valid_o`=1 and `bin_ready_i`=0.

## Timing
- Reset values: all outputs 0, state IDLE. Reset mid-pass aborts immediately, with no `done_o` and no write.
- `rd_en_o` is a single-cycle pulse. Read latency is exactly 1 cycle.
- Start to first `bin_valid_o`: 3 cycles. `start_i` is sampled at edge 0, READ is at cycle 1, WAIT at cycle 2, valid at cycle 3.
- Minimum 3 cycles per chunk with `bin_ready_i` held at 1.
- Full pass minimum: 3·NUM_CLASSES·NUM_CC + 1 cycles after start, i.e. 781 with defaults.
- `binarizing_o` rises the cycle after `start_i` and falls the cycle after `done_o`.
- `done_o` occurs the cycle after the final handshake.

## Configuration
- `CLASS_CLEAR_EN`:
  - Defined: in WAIT, `wr_en_o`=1 for one cycle with the same class/chunk as the preceding read. The memory writes all-zero counters, so the pass leaves the counter memory cleared for the next training run.
  - Undefined: `wr_en_o`, `wr_class_o` and `wr_chunk_o` are tied 0 and counters are preserved.

## Test plan
- Reset, then idle with defaults: all outputs 0. A `start_i` pulse gives `rd_en_o` at cycle 1 with address (0,0) and `binarizing_o`=1.
- `sample_cnt_i`=10; counters 6, 5, 0 and 511 in dims 0–3 produce bits 1, 0, 0, 1 (dim 1 is the tie → 0).
- `bin_ready_i` held at 0 for 20 cycles at chunk (2,4): `bin_valid_o` and the data stay stable, no new `rd_en_o` is issued, and the pass resumes on ready.
- Full pass with `bin_ready_i`=1: 260 handshakes in class-major order, `done_o` at cycle 781, then `binarizing_o`=0.
- `rst` asserted during chunk (5,3): all outputs go to 0 asynchronously; a later `start_i` restarts at (0,0).
- With `CLASS_CLEAR_EN`: `wr_en_o` fires once per chunk in WAIT with a matching address (260 writes in total). Without it, `wr_en_o` never asserts.
